// File: rtl/instruction_issuer.sv
// Program memory plus issue FSM feeding the 16-bit instruction stream to control_unit.
// Issues one op per clock, pausing on stall and draining the array after every MATMUL.
module instruction_issuer #(
  parameter int DEPTH         = 64,
  parameter int AW            = 6,
  parameter int MATMUL_CYCLES = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_data,
  input  logic          start,
  input  logic          stall,
  output logic [15:0]   instruction,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD,
    DONE
  } state_t;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_MM   = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;
  localparam logic [3:0] HOLD_N  = 4'(MATMUL_CYCLES);

  state_t      state;
  logic [15:0] mem [DEPTH];
  logic [3:0]  count;
  logic        last;
  logic [15:0] cur;
  logic [2:0]  op;
  logic        at_end;
  logic        is_halt;
  logic        is_mm;
  logic        is_nop;

  assign cur     = mem[pc];
  assign op      = cur[15:13];
  assign at_end  = (pc == AW'(DEPTH - 1));
  assign is_halt = (op == OP_HALT);
  assign is_mm   = (op == OP_MM);
  assign is_nop  = (op == OP_NOP);
  assign busy    = (state == ISSUE) || (state == HOLD);

  // Host may only rewrite the program while nothing is running.
  always_ff @(posedge clk) begin
    if (prog_we && (state == IDLE || state == DONE))
      mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= '0;
      instruction <= '0;
      instr_valid <= 1'b0;
      done        <= 1'b0;
      count       <= '0;
      last        <= 1'b0;
    end else begin
      instruction <= '0;
      instr_valid <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            pc    <= '0;
            done  <= 1'b0;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (!stall) begin
            unique case (1'b1)
              is_halt: begin
                done  <= 1'b1;
                state <= DONE;
              end
              is_mm: begin
                instruction <= cur;
                instr_valid <= 1'b1;
                pc          <= pc + AW'(1);
                count       <= HOLD_N;
                last        <= at_end;
                state       <= HOLD;
              end
              default: begin
                pc <= pc + AW'(1);
                if (!is_nop) begin
                  instruction <= cur;
                  instr_valid <= 1'b1;
                end
                if (at_end) begin
                  done  <= 1'b1;
                  state <= DONE;
                end
              end
            endcase
          end
        end
        HOLD: begin
          // Drain runs even under stall; a trailing MATMUL finishes here.
          count <= count - 4'd1;
          if (count == 4'd1) begin
            if (last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
